painel_row_scroller: RTL and testbench

Parametrised successor to the fixed 16-stage row rotator of the electronic panel. Holds one display row of WIDTH columns, initialised from a PATTERN parameter, and drives VISIBLE columns to the LED row. Adds parallel load, left/right rotation, a programmable step prescaler, and step/wrap status pulses. One instance is used per panel row; the panel controller shares mode and div across rows.

---
 rtl/painel_row_scroller.sv | 92 +++++++++
 tb/tb_painel_row_scroller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/painel_row_scroller.sv
// One panel row: a WIDTH-column rotating register preset from PATTERN.
// It drives the leftmost VISIBLE columns and emits registered step/wrap pulses.
module painel_row_scroller #(
  parameter int                     WIDTH   = 16,
  parameter int                     VISIBLE = 7,
  parameter logic [WIDTH-1:0]       PATTERN = 16'b1010_1000_1000_1000,
  parameter int                     DIV_W   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div,
  input  logic               load_en,
  input  logic [WIDTH-1:0]   load_data,
  output logic [VISIBLE-1:0] row_out,
  output logic               step_pulse,
  output logic               wrap
);

  localparam int                POS_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [POS_W-1:0]  POS_MAX = POS_W'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_PRESET = 2'b01;

  logic [WIDTH-1:0] row;
  logic [DIV_W-1:0] presc;
  logic [POS_W-1:0] pos;

  logic             tick;
  logic [POS_W-1:0] pos_left;
  logic [POS_W-1:0] pos_right;

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] r);
    return {r[WIDTH-2:0], r[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] r);
    return {r[0], r[WIDTH-1:1]};
  endfunction

  // Leftmost columns of the register are the visible ones.
  assign row_out = row[WIDTH-1 -: VISIBLE];

  // ">=" lets a div lowered below the running count tick on the next edge.
  assign tick      = (presc >= div);
  assign pos_left  = (pos == POS_MAX) ? '0 : pos + 1'b1;
  assign pos_right = (pos == '0) ? POS_MAX : pos - 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row        <= PATTERN;
      presc      <= '0;
      pos        <= '0;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else if (load_en) begin
      row        <= load_data;
      presc      <= '0;
      pos        <= '0;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else if (mode == MODE_PRESET) begin
      row        <= PATTERN;
      presc      <= '0;
      pos        <= '0;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else if (mode == MODE_HOLD) begin
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else if (!tick) begin
      presc      <= presc + 1'b1;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      presc      <= '0;
      step_pulse <= 1'b1;
      // mode[0] selects direction: 0 = left, 1 = right.
      if (!mode[0]) begin
        row  <= rot_left(row);
        pos  <= pos_left;
        wrap <= (pos_left == '0);
      end else begin
        row  <= rot_right(row);
        pos  <= pos_right;
        wrap <= (pos_right == '0);
      end
    end
  end

endmodule

// File: tb/tb_painel_row_scroller.sv
// Directed bench for painel_row_scroller with default parameters (WIDTH=16, VISIBLE=7).
module tb_painel_row_scroller;

  logic        CLK;
  logic        RST;
  logic [1:0]  mode;
  logic [3:0]  div;
  logic        load_en;
  logic [15:0] load_data;
  logic [6:0]  row_out;
  logic        step_pulse;
  logic        wrap;

  int n_checks;
  int n_fail;

  painel_row_scroller dut (
    .CLK        (CLK),
    .RST        (RST),
    .mode       (mode),
    .div        (div),
    .load_en    (load_en),
    .load_data  (load_data),
    .row_out    (row_out),
    .step_pulse (step_pulse),
    .wrap       (wrap)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    mode = 2'b10;
    div  = 4'd0;
    RST  = 1'b1;
    #1;
    n_checks++;
    if (row_out !== 7'b1010100) begin
      n_fail++; $display("FAIL reset_row_out got=%b exp=%b", row_out, 7'b1010100);
    end
    n_checks++;
    if (step_pulse !== 1'b0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses got=%b%b exp=00", step_pulse, wrap);
    end
    n_checks++;
    if (dut.row !== 16'hA888) begin
      n_fail++; $display("FAIL reset_row got=%h exp=a888", dut.row);
    end
    step();
    n_checks++;
    if (dut.row !== 16'hA888 || step_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_held_edge got=%h/%b exp=a888/0", dut.row, step_pulse);
    end
    RST = 1'b0;
  endtask

  task automatic test_rotate_left_div0();
    do_reset();
    mode = 2'b10;
    div  = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) begin
        n_checks++;
        if (dut.row !== 16'h5111 || row_out !== 7'b0101000) begin
          n_fail++; $display("FAIL left_first got=%h/%b exp=5111/0101000", dut.row, row_out);
        end
      end
      n_checks++;
      if (step_pulse !== 1'b1) begin
        n_fail++; $display("FAIL left_step k=%0d got=%b exp=1", k, step_pulse);
      end
      n_checks++;
      if (wrap !== (k == 16)) begin
        n_fail++; $display("FAIL left_wrap k=%0d got=%b exp=%b", k, wrap, (k == 16));
      end
    end
    n_checks++;
    if (dut.row !== 16'hA888) begin
      n_fail++; $display("FAIL left_full_turn got=%h exp=a888", dut.row);
    end
    step();
    n_checks++;
    if (wrap !== 1'b0 || dut.row !== 16'h5111) begin
      n_fail++; $display("FAIL left_after_wrap got=%b/%h exp=0/5111", wrap, dut.row);
    end
  endtask

  task automatic test_rotate_right_div3();
    mode = 2'b00;
    do_reset();
    mode = 2'b11;
    div  = 4'd3;
    for (int k = 1; k <= 64; k++) begin
      step();
      n_checks++;
      if (step_pulse !== (k % 4 == 0)) begin
        n_fail++; $display("FAIL right_step k=%0d got=%b exp=%b", k, step_pulse, (k % 4 == 0));
      end
      n_checks++;
      if (wrap !== (k == 64)) begin
        n_fail++; $display("FAIL right_wrap k=%0d got=%b exp=%b", k, wrap, (k == 64));
      end
      if (k == 3 || k == 4) begin
        n_checks++;
        if (dut.row !== ((k == 3) ? 16'hA888 : 16'h5444)) begin
          n_fail++; $display("FAIL right_row k=%0d got=%h", k, dut.row);
        end
      end
    end
    n_checks++;
    if (dut.row !== 16'hA888) begin
      n_fail++; $display("FAIL right_full_turn got=%h exp=a888", dut.row);
    end
  endtask

  task automatic test_load();
    mode = 2'b00;
    do_reset();
    mode      = 2'b10;
    div       = 4'd0;
    load_en   = 1'b1;
    load_data = 16'h00FF;
    step();
    load_en = 1'b0;
    n_checks++;
    if (dut.row !== 16'h00FF || dut.pos !== 4'd0 || dut.presc !== 4'd0) begin
      n_fail++; $display("FAIL load_state got=%h/%0d/%0d exp=00ff/0/0", dut.row, dut.pos, dut.presc);
    end
    n_checks++;
    if (step_pulse !== 1'b0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_pulses got=%b%b exp=00", step_pulse, wrap);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) begin
        n_checks++;
        if (dut.row !== 16'h01FE || step_pulse !== 1'b1) begin
          n_fail++; $display("FAIL load_next got=%h/%b exp=01fe/1", dut.row, step_pulse);
        end
      end
      n_checks++;
      if (wrap !== (k == 16)) begin
        n_fail++; $display("FAIL load_wrap k=%0d got=%b exp=%b", k, wrap, (k == 16));
      end
    end
  endtask

  task automatic test_hold();
    mode = 2'b00;
    do_reset();
    mode = 2'b10;
    div  = 4'd5;
    for (int k = 1; k <= 3; k++) step();
    n_checks++;
    if (dut.presc !== 4'd3 || step_pulse !== 1'b0) begin
      n_fail++; $display("FAIL hold_precount got=%0d/%b exp=3/0", dut.presc, step_pulse);
    end
    mode = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (dut.row !== 16'hA888 || dut.presc !== 4'd3 || step_pulse !== 1'b0) begin
        n_fail++; $display("FAIL hold_frozen k=%0d got=%h/%0d/%b exp=a888/3/0", k, dut.row, dut.presc, step_pulse);
      end
    end
    mode = 2'b10;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (step_pulse !== (k == 3)) begin
        n_fail++; $display("FAIL hold_resume k=%0d got=%b exp=%b", k, step_pulse, (k == 3));
      end
    end
    n_checks++;
    if (dut.row !== 16'h5111) begin
      n_fail++; $display("FAIL hold_resume_row got=%h exp=5111", dut.row);
    end
    // Lowering div below the running count must tick on the next edge.
    div = 4'd7;
    for (int k = 1; k <= 5; k++) step();
    div = 4'd2;
    step();
    n_checks++;
    if (step_pulse !== 1'b1 || dut.row !== 16'hA222) begin
      n_fail++; $display("FAIL div_lowered got=%b/%h exp=1/a222", step_pulse, dut.row);
    end
  endtask

  task automatic test_preset_and_async_reset();
    mode = 2'b00;
    do_reset();
    mode = 2'b10;
    div  = 4'd0;
    for (int k = 1; k <= 5; k++) step();
    n_checks++;
    if (dut.row !== 16'h1115) begin
      n_fail++; $display("FAIL five_left got=%h exp=1115", dut.row);
    end
    mode = 2'b01;
    step();
    n_checks++;
    if (dut.row !== 16'hA888 || dut.pos !== 4'd0 || step_pulse !== 1'b0) begin
      n_fail++; $display("FAIL preset got=%h/%0d/%b exp=a888/0/0", dut.row, dut.pos, step_pulse);
    end
    mode = 2'b10;
    step();
    n_checks++;
    if (dut.row !== 16'h5111 || step_pulse !== 1'b1) begin
      n_fail++; $display("FAIL preset_resume got=%h/%b exp=5111/1", dut.row, step_pulse);
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if (dut.row !== 16'hA888 || dut.presc !== 4'd0 || step_pulse !== 1'b0) begin
      n_fail++; $display("FAIL midtick_reset got=%h/%0d/%b exp=a888/0/0", dut.row, dut.presc, step_pulse);
    end
    step();
    n_checks++;
    if (dut.row !== 16'hA888 || step_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_over_tick got=%h/%b exp=a888/0", dut.row, step_pulse);
    end
    RST = 1'b0;
    step();
    n_checks++;
    if (dut.row !== 16'h5111 || step_pulse !== 1'b1) begin
      n_fail++; $display("FAIL after_reset_tick got=%h/%b exp=5111/1", dut.row, step_pulse);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    RST       = 1'b0;
    mode      = 2'b00;
    div       = 4'd0;
    load_en   = 1'b0;
    load_data = 16'h0000;
    step();
    step();
    test_reset();
    test_rotate_left_div0();
    test_rotate_right_div3();
    test_load();
    test_hold();
    test_preset_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
